// File: rtl/patch_step_scheduler.sv
// Finite-difference step sequencer for a 3-patch MLAB: reads neighbour operands,
// hands them to a fixed-latency compute unit, writes the result and rotates patch roles.
module patch_step_scheduler #(
  parameter int PATCH_SIZE = 16,
  parameter int DATA_W     = 18,
  parameter int COMP_LAT   = 1,
  parameter int STEP_W     = 16,
  localparam int AW        = $clog2(PATCH_SIZE)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [STEP_W-1:0]        num_steps,
  output logic                     busy,
  output logic                     done,
  output logic [STEP_W-1:0]        step_cnt,
  output logic [AW-1:0]            mem_addr,
  output logic [1:0]               mem_patch,
  output logic                     mem_we,
  output logic signed [DATA_W-1:0] mem_wdata,
  input  logic signed [DATA_W-1:0] mem_rdata,
  output logic signed [DATA_W-1:0] c_left,
  output logic signed [DATA_W-1:0] c_centre,
  output logic signed [DATA_W-1:0] c_right,
  output logic signed [DATA_W-1:0] c_prev,
  output logic                     c_valid,
  input  logic signed [DATA_W-1:0] c_result
);

  // state  | meaning
  // IDLE   | waiting for start
  // RD_L   | address left neighbour (curr)
  // RD_C   | address centre (curr), capture left
  // RD_R   | address right neighbour (curr), capture centre
  // RD_P   | address same node (prev), capture right
  // CAP    | capture prev operand
  // COMP   | wait COMP_LAT cycles for the compute unit
  // WR     | write result to next patch
  // ROTATE | advance patch roles, count step
  // DONE   | one-cycle completion pulse
  typedef enum logic [3:0] {
    IDLE, RD_L, RD_C, RD_R, RD_P, CAP, COMP, WR, ROTATE, DONE
  } state_t;

  localparam int LW = (COMP_LAT > 1) ? $clog2(COMP_LAT) : 1;
  localparam logic [AW-1:0] LAST   = AW'(PATCH_SIZE - 1);
  localparam logic [LW-1:0] LAT_TC = LW'(COMP_LAT - 1);

  state_t state_q, state_d;
  logic [AW-1:0] node_q, node_d;
  logic [STEP_W-1:0] steps_q, steps_d, step_cnt_q, step_cnt_d;
  logic [1:0] prev_q, prev_d, curr_q, curr_d, next_q, next_d;
  logic [LW-1:0] lat_q, lat_d;
  logic signed [DATA_W-1:0] left_q, left_d, centre_q, centre_d, right_q, right_d;
  logic signed [DATA_W-1:0] prevop_q, prevop_d, wdata_q, wdata_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      node_q     <= '0;
      steps_q    <= '0;
      step_cnt_q <= '0;
      prev_q     <= 2'd0;
      curr_q     <= 2'd1;
      next_q     <= 2'd2;
      lat_q      <= '0;
      left_q     <= '0;
      centre_q   <= '0;
      right_q    <= '0;
      prevop_q   <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      node_q     <= node_d;
      steps_q    <= steps_d;
      step_cnt_q <= step_cnt_d;
      prev_q     <= prev_d;
      curr_q     <= curr_d;
      next_q     <= next_d;
      lat_q      <= lat_d;
      left_q     <= left_d;
      centre_q   <= centre_d;
      right_q    <= right_d;
      prevop_q   <= prevop_d;
      wdata_q    <= wdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    node_d     = node_q;
    steps_d    = steps_q;
    step_cnt_d = step_cnt_q;
    prev_d     = prev_q;
    curr_d     = curr_q;
    next_d     = next_q;
    lat_d      = lat_q;
    left_d     = left_q;
    centre_d   = centre_q;
    right_d    = right_q;
    prevop_d   = prevop_q;
    wdata_d    = wdata_q;
    mem_addr   = '0;
    mem_patch  = 2'd0;
    mem_we     = 1'b0;
    c_valid    = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          steps_d    = num_steps;
          step_cnt_d = '0;
          node_d     = '0;
          state_d    = (num_steps == '0) ? DONE : RD_L;
        end
      end
      RD_L: begin
        mem_addr  = (node_q == '0) ? '0 : node_q - AW'(1);
        mem_patch = curr_q;
        state_d   = RD_C;
      end
      RD_C: begin
        mem_addr  = node_q;
        mem_patch = curr_q;
        left_d    = (node_q == '0) ? '0 : mem_rdata;
        state_d   = RD_R;
      end
      RD_R: begin
        mem_addr  = (node_q == LAST) ? node_q : node_q + AW'(1);
        mem_patch = curr_q;
        centre_d  = mem_rdata;
        state_d   = RD_P;
      end
      RD_P: begin
        mem_addr  = node_q;
        mem_patch = prev_q;
        right_d   = (node_q == LAST) ? '0 : mem_rdata;
        state_d   = CAP;
      end
      CAP: begin
        prevop_d = mem_rdata;
        lat_d    = LAT_TC;
        state_d  = COMP;
      end
      COMP: begin
        c_valid = (lat_q == LAT_TC);
        if (lat_q == '0) begin
          wdata_d = c_result;
          state_d = WR;
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      WR: begin
        mem_we    = 1'b1;
        mem_addr  = node_q;
        mem_patch = next_q;
        if (node_q == LAST) begin
          state_d = ROTATE;
        end else begin
          node_d  = node_q + AW'(1);
          state_d = RD_L;
        end
      end
      ROTATE: begin
        prev_d     = curr_q;
        curr_d     = next_q;
        next_d     = prev_q;
        step_cnt_d = step_cnt_q + STEP_W'(1);
        node_d     = '0;
        state_d    = (step_cnt_q + STEP_W'(1) == steps_q) ? DONE : RD_L;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign step_cnt  = step_cnt_q;
  assign mem_wdata = wdata_q;
  assign c_left    = left_q;
  assign c_centre  = centre_q;
  assign c_right   = right_q;
  assign c_prev    = prevop_q;

endmodule

// File: tb/tb_patch_step_scheduler.sv
// Scoreboard bench: two scheduler instances (COMP_LAT 1 and 3) share stimulus, each with
// its own MLAB and compute-unit model; a step-level reference model fills the queues.
module tb_patch_step_scheduler;
  localparam int N = 16;
  localparam int W = 18;

  typedef struct { int l; int c; int r; int p; } op_t;
  typedef struct { int patch; int addr; int data; int cyc; } wr_t;
  typedef struct { int cyc; int steps; int busy; } dn_t;

  logic clk = 1'b0;
  logic rst_n, start, ld;
  logic [15:0] num_steps;
  logic [1:0] any_out, busy_v;
  logic signed [W-1:0] init_img [3][N];

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int mdl [3][N];
  int rp, rc, rn;

  op_t oq [2][$];
  wr_t wq [2][$];
  dn_t dq [2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input bit ok, input int act, input int exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic signed [W-1:0] f(input int l, input int r, input int p);
    int v;
    v = l + r - p;
    return v[W-1:0];
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = (g == 0) ? 1 : 3;
    logic busy, done, mem_we, c_valid;
    logic [15:0] step_cnt;
    logic [3:0] mem_addr;
    logic [1:0] mem_patch;
    logic signed [W-1:0] mem_wdata, mem_rdata, c_left, c_centre, c_right, c_prev, c_result;
    logic signed [W-1:0] mem [3][N];
    int wcount = 0;
    int bcnt = 0;
    int vcyc = 0;
    bit pend = 1'b0;
    op_t held, o;
    wr_t w;
    dn_t d;

    patch_step_scheduler #(.COMP_LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_steps(num_steps),
      .busy(busy), .done(done), .step_cnt(step_cnt),
      .mem_addr(mem_addr), .mem_patch(mem_patch), .mem_we(mem_we),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .c_left(c_left), .c_centre(c_centre), .c_right(c_right), .c_prev(c_prev),
      .c_valid(c_valid), .c_result(c_result)
    );

    assign any_out[g] = busy | done | mem_we | c_valid | (|step_cnt) | (|mem_addr) |
                        (|mem_patch) | (|mem_wdata) | (|c_left) | (|c_centre) |
                        (|c_right) | (|c_prev);
    assign busy_v[g] = busy;

    always @(posedge clk) begin
      if (ld) mem <= init_img;
      else if (mem_we && mem_patch != 2'd3) mem[mem_patch][mem_addr] <= mem_wdata;
      mem_rdata <= (mem_patch == 2'd3) ? '0 : mem[mem_patch][mem_addr];
    end

    always @(negedge clk) begin
      if (!rst_n) begin
        pend = 1'b0;
        bcnt = 0;
        c_result = '0;
      end else begin
        if (busy) bcnt++;
        if (mem_patch == 2'd3) chk($sformatf("lat%0d_patch3", LAT), 1'b0, 3, 2);
        if (c_valid) begin
          if (oq[g].size() == 0) chk($sformatf("lat%0d_cvalid_unexpected", LAT), 1'b0, 1, 0);
          else begin
            o = oq[g].pop_front();
            chk($sformatf("lat%0d_op_left", LAT), int'(c_left) == o.l, int'(c_left), o.l);
            chk($sformatf("lat%0d_op_centre", LAT), int'(c_centre) == o.c, int'(c_centre), o.c);
            chk($sformatf("lat%0d_op_right", LAT), int'(c_right) == o.r, int'(c_right), o.r);
            chk($sformatf("lat%0d_op_prev", LAT), int'(c_prev) == o.p, int'(c_prev), o.p);
          end
          held.l = int'(c_left);
          held.c = int'(c_centre);
          held.r = int'(c_right);
          held.p = int'(c_prev);
          vcyc = cyc;
          pend = 1'b1;
        end
        // result is only meaningful in the cycle the scheduler must sample it
        if (pend && cyc == vcyc + LAT - 1) begin
          c_result = f(int'(c_left), int'(c_right), int'(c_prev));
          pend = 1'b0;
        end else begin
          c_result = W'($urandom);
        end
        if (mem_we) begin
          wcount++;
          if (wq[g].size() == 0) chk($sformatf("lat%0d_write_unexpected", LAT), 1'b0, 1, 0);
          else begin
            w = wq[g].pop_front();
            chk($sformatf("lat%0d_wr_patch", LAT), int'(mem_patch) == w.patch, int'(mem_patch), w.patch);
            chk($sformatf("lat%0d_wr_addr", LAT), int'(mem_addr) == w.addr, int'(mem_addr), w.addr);
            chk($sformatf("lat%0d_wr_data", LAT), int'(mem_wdata) == w.data, int'(mem_wdata), w.data);
            chk($sformatf("lat%0d_wr_cycle", LAT), cyc == w.cyc, cyc, w.cyc);
            chk($sformatf("lat%0d_op_hold_l", LAT), int'(c_left) == held.l, int'(c_left), held.l);
            chk($sformatf("lat%0d_op_hold_r", LAT), int'(c_right) == held.r, int'(c_right), held.r);
            chk($sformatf("lat%0d_op_hold_p", LAT), int'(c_prev) == held.p, int'(c_prev), held.p);
          end
        end
        if (done) begin
          if (dq[g].size() == 0) chk($sformatf("lat%0d_done_unexpected", LAT), 1'b0, 1, 0);
          else begin
            d = dq[g].pop_front();
            chk($sformatf("lat%0d_done_cycle", LAT), cyc == d.cyc, cyc, d.cyc);
            chk($sformatf("lat%0d_step_cnt", LAT), int'(step_cnt) == d.steps, int'(step_cnt), d.steps);
            chk($sformatf("lat%0d_busy_cycles", LAT), bcnt == d.busy, bcnt, d.busy);
          end
          bcnt = 0;
        end
      end
    end
  end

  task automatic load(input bit rnd);
    int v;
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < N; i++) begin
        if (rnd) v = int'($urandom_range(40000)) - 20000;
        else v = (p == 1) ? i : ((p == 0) ? 5 : 0);
        init_img[p][i] = W'(v);
        mdl[p][i] = int'(init_img[p][i]);
      end
    @(posedge clk); #1 ld = 1'b1;
    @(posedge clk); #1 ld = 1'b0;
  endtask

  task automatic run(input int ns, input int extra);
    int c0, lat, cost, l, r, res, tmp, w0, w1;
    int img [N];
    bit ok;
    op_t op;
    wr_t wr;
    dn_t dn;
    @(posedge clk); #1;
    start = 1'b1;
    num_steps = 16'(ns);
    c0 = cyc;
    w0 = lane[0].wcount;
    w1 = lane[1].wcount;
    for (int s = 0; s < ns; s++) begin
      for (int i = 0; i < N; i++) begin
        l = (i == 0) ? 0 : mdl[rc][i-1];
        r = (i == N - 1) ? 0 : mdl[rc][i+1];
        res = int'(f(l, r, mdl[rp][i]));
        op.l = l; op.c = mdl[rc][i]; op.r = r; op.p = mdl[rp][i];
        for (int g = 0; g < 2; g++) begin
          lat = (g == 0) ? 1 : 3;
          cost = N * (6 + lat) + 1;
          wr.patch = rn;
          wr.addr = i;
          wr.data = res;
          wr.cyc = c0 + 1 + s * cost + i * (6 + lat) + 5 + lat;
          oq[g].push_back(op);
          wq[g].push_back(wr);
        end
        img[i] = res;
      end
      mdl[rn] = img;
      tmp = rp; rp = rc; rc = rn; rn = tmp;
    end
    for (int g = 0; g < 2; g++) begin
      lat = (g == 0) ? 1 : 3;
      cost = N * (6 + lat) + 1;
      dn.cyc = c0 + 1 + ns * cost;
      dn.steps = ns;
      dn.busy = ns * cost + 1;
      dq[g].push_back(dn);
    end
    ok = 1'b0;
    for (int k = 0; k < ns * 160 + 20; k++) begin
      @(posedge clk); #1;
      start = (extra > 0 && cyc == c0 + extra);
      if (dq[0].size() == 0 && dq[1].size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    start = 1'b0;
    chk("run_completed", ok, int'(ok), 1);
    chk("lat1_write_count", lane[0].wcount - w0 == N * ns, lane[0].wcount - w0, N * ns);
    chk("lat3_write_count", lane[1].wcount - w1 == N * ns, lane[1].wcount - w1, N * ns);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, w0, w1;
    rst_n = 1'b0; start = 1'b0; ld = 1'b0; num_steps = '0;
    rp = 0; rc = 1; rn = 2;
    repeat (3) @(posedge clk); #1;
    chk("reset_outputs", any_out == 2'b00, int'(any_out), 0);
    rst_n = 1'b1;

    load(1'b0);
    run(1, 0);
    chk("det_node0_lat1", int'(lane[0].mem[2][0]) == -4, int'(lane[0].mem[2][0]), -4);
    chk("det_node5_lat1", int'(lane[0].mem[2][5]) == 5, int'(lane[0].mem[2][5]), 5);
    chk("det_node15_lat1", int'(lane[0].mem[2][15]) == 9, int'(lane[0].mem[2][15]), 9);
    chk("det_node0_lat3", int'(lane[1].mem[2][0]) == -4, int'(lane[1].mem[2][0]), -4);
    chk("det_node15_lat3", int'(lane[1].mem[2][15]) == 9, int'(lane[1].mem[2][15]), 9);

    run(1, 50);
    run(0, 0);

    @(posedge clk); #1;
    start = 1'b1; num_steps = 16'd3; c0 = cyc;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy_before", busy_v == 2'b11, int'(busy_v), 3);
    rst_n = 1'b0;
    rp = 0; rc = 1; rn = 2;
    #1;
    chk("abort_outputs_zero", any_out == 2'b00, int'(any_out), 0);
    w0 = lane[0].wcount;
    w1 = lane[1].wcount;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("abort_no_write_lat1", lane[0].wcount == w0, lane[0].wcount - w0, 0);
    chk("abort_no_write_lat3", lane[1].wcount == w1, lane[1].wcount - w1, 0);
    chk("abort_idle_outputs", any_out == 2'b00, int'(any_out), 0);

    load(1'b1);
    run(4, 0);
    run(1, 0);
    for (int t = 0; t < 3; t++) begin
      if (t != 1) load(1'b1);
      run(int'($urandom_range(3, 1)), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
